// File: rtl/fifo_drain_if.sv
// rtl/fifo_drain_if.sv - FIFO read port plus downstream valid/ready stream bundle
interface fifo_drain_if #(
   parameter int DATA_W = 8
);
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_dout;
   logic              rd;
   logic [DATA_W-1:0] m_data;
   logic              m_valid;
   logic              m_ready;

   // The drain reads the FIFO and sources the stream
   modport master (
      input  fifo_empty,
      input  fifo_dout,
      output rd,
      output m_data,
      output m_valid,
      input  m_ready
   );

   // FIFO plus consumer side
   modport slave (
      output fifo_empty,
      output fifo_dout,
      input  rd,
      input  m_data,
      input  m_valid,
      output m_ready
   );
endinterface

// File: rtl/fifo_drain.sv
// rtl/fifo_drain.sv - credit-checked FIFO drain into a 2-entry stream buffer; FIFO_DRAIN_STATS_EN adds counters
module fifo_drain #(
   parameter int DATA_W    = 8,
   parameter int BUF_DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst,
   fifo_drain_if.master  bus
`ifdef FIFO_DRAIN_STATS_EN
   ,
   output logic [15:0]   words_out,
   output logic [15:0]   stall_cnt
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_t;

   localparam logic [2:0] CREDITS = 3'(BUF_DEPTH);

   occ_t              occ;
   logic              inflight;
   logic              m_valid_q;
   logic [DATA_W-1:0] buf_head;
   logic [DATA_W-1:0] buf_tail;
   logic              pop;
   logic              rd_c;
   logic [2:0]        credit;

   assign pop         = m_valid_q && bus.m_ready;
   assign bus.rd      = rd_c;
   assign bus.m_valid = m_valid_q;
   assign bus.m_data  = buf_head;

   // Request a word only if a buffer slot is certain to be free when it lands
   always_comb begin
      credit = {1'b0, occ} + {2'b00, inflight};
      rd_c   = !rst && !bus.fifo_empty && (credit < (CREDITS + {2'b00, pop}));
   end

   // Occupancy FSM: track in-flight read, capture returning data, shift on pop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ       <= EMPTY;
         inflight  <= 1'b0;
         m_valid_q <= 1'b0;
         buf_head  <= '0;
         buf_tail  <= '0;
      end else begin
         inflight <= rd_c;
         case (occ)
            EMPTY: begin
               if (inflight) begin
                  buf_head  <= bus.fifo_dout;
                  occ       <= ONE;
                  m_valid_q <= 1'b1;
               end
            end
            ONE: begin
               case ({inflight, pop})
                  2'b10: begin
                     buf_tail <= bus.fifo_dout;
                     occ      <= TWO;
                  end
                  2'b01: begin
                     occ       <= EMPTY;
                     m_valid_q <= 1'b0;
                  end
                  2'b11: begin
                     buf_head <= bus.fifo_dout;
                  end
                  default: ;
               endcase
            end
            TWO: begin
               // Credit check keeps inflight low here, so only a pop can occur
               if (pop) begin
                  buf_head <= buf_tail;
                  occ      <= ONE;
               end
            end
            default: begin
               occ       <= EMPTY;
               m_valid_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef FIFO_DRAIN_STATS_EN
   // Count delivered words (wrapping) and stalled cycles (saturating)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         words_out <= 16'd0;
         stall_cnt <= 16'd0;
      end else begin
         if (pop) begin
            words_out <= words_out + 16'd1;
         end
         if (m_valid_q && !bus.m_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// tb/tb_fifo_drain.sv - scoreboard bench for fifo_drain with a 16-deep FIFO model
module tb_fifo_drain;
   localparam int DW     = 8;
   localparam int FDEPTH = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fifo_drain_if #(.DATA_W(DW)) bus();

`ifdef FIFO_DRAIN_STATS_EN
   logic [15:0] words_out;
   logic [15:0] stall_cnt;
`endif

   fifo_drain #(.DATA_W(DW), .BUF_DEPTH(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef FIFO_DRAIN_STATS_EN
      ,
      .words_out (words_out),
      .stall_cnt (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int rd_pulses = 0;
   int pops = 0;

   logic [DW-1:0] fq[$];
   logic [DW-1:0] exp_q[$];
   logic          wr_en = 1'b0;
   logic [DW-1:0] wr_data = '0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   // FIFO model: a write is kept only if there is room, and every kept word is
   // expected downstream in write order
   initial begin
      logic          r;
      logic          w;
      logic [DW-1:0] d;
      bus.fifo_empty = 1'b1;
      bus.fifo_dout  = '0;
      forever begin
         @(posedge clk);
         r = bus.rd;
         w = wr_en;
         d = wr_data;
         #1;
         if (r) begin
            rd_pulses++;
            if (fq.size() > 0) bus.fifo_dout = fq.pop_front();
         end
         if (w && fq.size() < FDEPTH) begin
            fq.push_back(d);
            exp_q.push_back(d);
         end
         bus.fifo_empty = (fq.size() == 0);
      end
   end

   // Monitor: compare each accepted word, hold stability during stalls, no underflow
   initial begin
      logic          prev_stall;
      logic [DW-1:0] prev_data;
      logic [DW-1:0] e;
      prev_stall = 1'b0;
      prev_data  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (bus.rd) check("rd_while_empty", 32'(bus.fifo_empty), 32'd0);
            if (prev_stall) begin
               check("stall_valid_held", 32'(bus.m_valid), 32'd1);
               check("stall_data_held", 32'(bus.m_data), 32'(prev_data));
            end
            if (bus.m_valid && bus.m_ready) begin
               pops++;
               if (exp_q.size() == 0) begin
                  check("spurious_word", 32'(bus.m_data), 32'hFFFF_FFFF);
               end else begin
                  e = exp_q.pop_front();
                  check("stream_data", 32'(bus.m_data), 32'(e));
               end
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [DW-1:0] v);
      wr_en   = 1'b1;
      wr_data = v;
      tick();
      wr_en   = 1'b0;
   endtask

   // Reset discards buffered and in-flight words; the FIFO itself keeps its contents
   task automatic assert_rst();
      rst   = 1'b1;
      exp_q = fq;
   endtask

   task automatic wait_idle(input int bound);
      int   n;
      logic done;
      n    = 0;
      done = 1'b0;
      while (n < bound && !done) begin
         tick();
         n++;
         done = (exp_q.size() == 0) && (fq.size() == 0) && !bus.m_valid && !bus.rd;
      end
      check("drain_done", 32'(done), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int            lat;
      int            run;
      int            base;
      logic [DW-1:0] w0;
      logic [DW-1:0] head;
      logic [DW-1:0] alt_vals[6];
      alt_vals = '{8'd3, 8'd7, 8'd1, 8'd5, 8'd0, 8'd2};

      bus.m_ready = 1'b0;
      tick();

      // Reset while FIFO holds 3 words
      for (int i = 0; i < 3; i++) write_word(8'($urandom));
      check("rst_rd", 32'(bus.rd), 32'd0);
      check("rst_valid", 32'(bus.m_valid), 32'd0);
      check("rst_data", 32'(bus.m_data), 32'd0);
      bus.m_ready = 1'b1;
      rst = 1'b0;
      #1;
      check("rd_after_release", 32'(bus.rd), 32'd1);
      tick();
      wait_idle(50);

      // 17 writes into a 16-deep FIFO, then full-rate drain
      assert_rst();
      for (int i = 0; i <= 16; i++) write_word(8'(i));
      rst = 1'b0;
      lat = 0;
      @(negedge clk);
      while (!bus.m_valid && lat < 10) begin
         lat++;
         @(negedge clk);
      end
      check("first_valid_latency", 32'(lat), 32'd2);
      run = 0;
      while (bus.m_valid && run < 40) begin
         run++;
         @(negedge clk);
      end
      check("burst_len", 32'(run), 32'd16);
      check("rd_low_after_drain", 32'(bus.rd), 32'd0);
      tick();
      wait_idle(20);

      // Stalled consumer with 5 words: exactly two reads, head held
      bus.m_ready = 1'b0;
      #2;
      base = rd_pulses;
      tick();
      w0 = 8'($urandom);
      write_word(w0);
      for (int i = 0; i < 4; i++) write_word(8'($urandom));
      for (int i = 0; i < 6; i++) tick();
      check("stall_rd_pulses", 32'(rd_pulses - base), 32'd2);
      check("stall_valid", 32'(bus.m_valid), 32'd1);
      check("stall_head", 32'(bus.m_data), 32'(w0));
      bus.m_ready = 1'b1;
      run = 0;
      @(negedge clk);
      while (bus.m_valid && run < 20) begin
         run++;
         @(negedge clk);
      end
      check("unstall_no_gaps", 32'(run), 32'd5);
      tick();
      wait_idle(20);

      // Alternating single writes with m_ready toggling every cycle
      base = pops;
      for (int i = 0; i < 6; i++) begin
         wr_en       = 1'b1;
         wr_data     = alt_vals[i];
         bus.m_ready = ~bus.m_ready;
         tick();
         wr_en       = 1'b0;
         bus.m_ready = ~bus.m_ready;
         tick();
      end
      bus.m_ready = 1'b1;
      wait_idle(30);
      check("alt_count", 32'(pops - base), 32'd6);

      // Async reset between edges while a read is in flight
      assert_rst();
      for (int i = 0; i < 8; i++) write_word(8'($urandom));
      rst = 1'b0;
      bus.m_ready = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      check("burst_rd_active", 32'(bus.rd), 32'd1);
      #2;
      head = fq[0];
      assert_rst();
      #1;
      check("async_valid_drop", 32'(bus.m_valid), 32'd0);
      tick();
      rst = 1'b0;
      run = 0;
      @(negedge clk);
      while (!bus.m_valid && run < 10) begin
         run++;
         @(negedge clk);
      end
      check("post_reset_head", 32'(bus.m_data), 32'(head));
      tick();
      wait_idle(30);

      // Randomized writes and consumer stalls
      for (int c = 0; c < 400; c++) begin
         wr_en       = ($urandom_range(0, 2) != 0);
         wr_data     = 8'($urandom);
         bus.m_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      wr_en = 1'b0;
      bus.m_ready = 1'b1;
      wait_idle(100);

`ifdef FIFO_DRAIN_STATS_EN
      // 10 words with exactly 4 stall cycles, then reset clears counters
      bus.m_ready = 1'b0;
      assert_rst();
      tick();
      check("stats_rst_words", 32'(words_out), 32'd0);
      check("stats_rst_stall", 32'(stall_cnt), 32'd0);
      for (int i = 0; i < 10; i++) write_word(8'($urandom));
      rst = 1'b0;
      run = 0;
      while (!bus.m_valid && run < 10) begin
         tick();
         run++;
      end
      for (int i = 0; i < 4; i++) tick();
      bus.m_ready = 1'b1;
      wait_idle(40);
      check("stats_words", 32'(words_out), 32'd10);
      check("stats_stall", 32'(stall_cnt), 32'd4);
      #2;
      assert_rst();
      #1;
      check("stats_clr_words", 32'(words_out), 32'd0);
      check("stats_clr_stall", 32'(stall_cnt), 32'd0);
      tick();
      rst = 1'b0;
      tick();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fifo_drain.md
Name: fifo_drain

Overview:
- Read-side master for the 8-bit, 16-deep flagged FIFO (`fifo_flag`).
- Watches the FIFO `empty` flag, issues single-cycle `rd` strobes and captures `d_out` one cycle after each strobe.
- Presents captured words downstream on a valid/ready stream through a 2-entry output buffer.
- Sits between any `fifo_flag` instance and a consumer that may stall, sustaining one word per clock when the consumer does not stall.

Parameters:
- DATA_W, 8, width of FIFO data and output stream.
- BUF_DEPTH, 2, output buffer entries; fixed at 2, since the credit logic below requires it.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- fifo_empty  input  1  FIFO empty flag; updates on the same edge that consumes a read
- fifo_dout  input  DATA_W  FIFO read data; valid in the cycle after `rd` was sampled high
- rd  output  1  FIFO read strobe
- m_data  output  DATA_W  stream data (head of buffer)
- m_valid  output  1  stream data valid
- m_ready  input  1  consumer accepts `m_data` when `m_valid && m_ready`

Behaviour:
- Reset (async assert, sync release):
  - `rd` = 0, `m_valid` = 0, `m_data` = 0.
  - Buffer occupancy `occ` = 0; `inflight` = 0; both buffer entries cleared.
- pop = `m_valid && m_ready`.
- `rd` (combinational) = !`rst` && !`fifo_empty` && ((`occ` + `inflight` − pop) < 2).
  - This is a credit check: a word is never requested unless a buffer slot is guaranteed free on arrival.
  - Combinational path from `m_ready` to `rd` is allowed.
- `inflight` <= `rd` each cycle.
- When `inflight` = 1, `fifo_dout` is written into the buffer at that edge.
- Occupancy FSM (`occ` states):
  - EMPTY (0): `m_valid` = 0. Capture → ONE.
  - ONE (1): `m_valid` = 1. Capture without pop → TWO. Pop without capture → EMPTY. Capture and pop together → stay ONE, new word becomes head.
  - TWO (2): `m_valid` = 1, no capture possible (credit check). Pop → ONE, second entry moves to head.
- Order: strict FIFO order. Head entry held stable while `m_valid && !m_ready`; `m_data` must not change during a stall.
- Latency: `fifo_empty` falls in cycle N → `rd` high in cycle N → word captured at end of N+1 → `m_valid` high in cycle N+2.
- Throughput: 1 word/clk when `m_ready` is held high and the FIFO is not empty.
- `fifo_empty` rises while `inflight` = 1: the in-flight word is still captured; no further `rd`.
- Overflow: `rd` never asserted while `fifo_empty` = 1, so no FIFO underflow. Buffer can never overflow (credit invariant `occ` + `inflight` ≤ 2).
- Reset mid-operation: in-flight and buffered words are discarded; `m_valid` drops immediately (async).
- `m_data` holds its last value when `m_valid` = 0; the consumer must not rely on it.

Optional Feature:
- Macro: `FIFO_DRAIN_STATS_EN`.
- When defined:
  - Adds output `words_out` [15:0], counting pop events; reset 0; wraps 0xFFFF → 0x0000.
  - Adds output `stall_cnt` [15:0], counting cycles with `m_valid && !m_ready`; saturates at 0xFFFF.
- When undefined: neither port nor its counters exist; all other behaviour is identical.

Test Plan:
- Reset with FIFO holding 3 words: assert `rst` for 1 cycle → `rd` = 0, `m_valid` = 0, `m_data` = 0; after release, `rd` rises in the first cycle with `fifo_empty` = 0.
- Write 17 words 0..16 into a 16-deep FIFO, `m_ready` = 1 → `m_data` sequence 0..15, one per clock after 2-cycle latency; word 16 dropped by the FIFO (full); `rd` falls when `fifo_empty` rises.
- `m_ready` = 0 with FIFO holding 5 words → exactly 2 `rd` pulses, `occ` = 2, `m_data` = first word held stable; raise `m_ready` → remaining words delivered in order, no gaps.
- Alternating single write/read of values 3, 7, 1, 5, 0, 2 with `m_ready` toggling every cycle → output order 3, 7, 1, 5, 0, 2; `rd` never high while `fifo_empty` = 1.
- Async `rst` pulse mid-burst, between clock edges with `inflight` = 1 → `m_valid` drops immediately; after release, no stale word appears; next output is the FIFO's current head.
- With `FIFO_DRAIN_STATS_EN`: deliver 10 words with 4 stall cycles → `words_out` = 10, `stall_cnt` = 4; `rst` clears both to 0.
